// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART ASCII command parser.
package uart_cmd_parser_pkg;

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_ADDR_HI,
    ST_CMD_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_TERM,
    ST_DISCARD
  } state_e;

  typedef enum logic {
    OP_WR,
    OP_RD
  } op_e;

endpackage

// File: rtl/uart_hex_nibble.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f -> nibble plus validity flag.
module uart_hex_nibble (
  input  logic [7:0] i_byte,
  output logic [3:0] o_nibble,
  output logic       o_is_hex
);

  always_comb begin
    o_nibble = 4'h0;
    o_is_hex = 1'b0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      o_nibble = i_byte[3:0];
      o_is_hex = 1'b1;
    end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                 (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
      // low nibble of 'A'/'a' is 1, so adding 9 yields 10
      o_nibble = i_byte[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "W AH AL DH DL TERM" / "R AH AL TERM" ASCII frames into register-bus strobes.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
//
// state          | meaning
// ST_IDLE        | waiting for 'W'/'R'; bare terminators ignored
// ST_CMD_ADDR_HI | expecting address high nibble
// ST_CMD_ADDR_LO | expecting address low nibble
// ST_DATA_HI     | expecting data high nibble (write only)
// ST_DATA_LO     | expecting data low nibble (write only)
// ST_TERM        | expecting LF/CR to commit the frame
// ST_DISCARD     | dropping bytes after an error until LF/CR
module uart_cmd_parser #(
  parameter int TIMEOUT_TICKS = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  output logic       err
);
  import uart_cmd_parser_pkg::*;

  state_e     r_state, w_state_nxt;
  op_e        r_op, w_op_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_wr_en, r_rd_en, r_err;
  logic       w_wr_nxt, w_rd_nxt, w_err_nxt;
  logic [7:0] r_wr_addr, r_wr_data, r_rd_addr;
  logic [3:0] w_nibble;
  logic       w_is_hex, w_is_term, w_tmo;

  uart_hex_nibble u_hex (
    .i_byte   (rx_data),
    .o_nibble (w_nibble),
    .o_is_hex (w_is_hex)
  );

  assign w_is_term = (rx_data == CH_LF) || (rx_data == CH_CR);

`ifdef UART_CMD_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        w_in_frame;

  assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_DISCARD);
  assign w_tmo = baud_tick && w_in_frame && (r_tmo_cnt == 16'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo_cnt <= 16'h0;
    else if (rx_valid || w_state_nxt == ST_IDLE)
      r_tmo_cnt <= 16'h0;
    else if (baud_tick && w_in_frame)
      r_tmo_cnt <= r_tmo_cnt + 16'h1;
  end
`else
  logic w_unused;
  assign w_unused = ^{baud_tick, TIMEOUT_TICKS[0]};
  assign w_tmo    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == CH_W) begin
            w_state_nxt = ST_CMD_ADDR_HI;
            w_op_nxt    = OP_WR;
          end else if (rx_data == CH_R) begin
            w_state_nxt = ST_CMD_ADDR_HI;
            w_op_nxt    = OP_RD;
          end else if (!w_is_term) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DISCARD;
          end
        end
        ST_CMD_ADDR_HI, ST_CMD_ADDR_LO, ST_DATA_HI, ST_DATA_LO: begin
          if (w_is_hex) begin
            if (r_state == ST_CMD_ADDR_HI || r_state == ST_CMD_ADDR_LO)
              w_addr_nxt = {r_addr[3:0], w_nibble};
            else
              w_data_nxt = {r_data[3:0], w_nibble};
            case (r_state)
              ST_CMD_ADDR_HI: w_state_nxt = ST_CMD_ADDR_LO;
              ST_CMD_ADDR_LO: w_state_nxt = (r_op == OP_WR) ? ST_DATA_HI : ST_TERM;
              ST_DATA_HI:     w_state_nxt = ST_DATA_LO;
              default:        w_state_nxt = ST_TERM;
            endcase
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = w_is_term ? ST_IDLE : ST_DISCARD;
          end
        end
        ST_TERM: begin
          if (w_is_term) begin
            w_state_nxt = ST_IDLE;
            w_wr_nxt    = (r_op == OP_WR);
            w_rd_nxt    = (r_op == OP_RD);
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (w_is_term)
            w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_tmo) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_WR;
      r_addr    <= 8'h0;
      r_data    <= 8'h0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_err     <= 1'b0;
      r_wr_addr <= 8'h0;
      r_wr_data <= 8'h0;
      r_rd_addr <= 8'h0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_wr_en <= w_wr_nxt;
      r_rd_en <= w_rd_nxt;
      r_err   <= w_err_nxt;
      if (w_wr_nxt) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_data;
      end
      if (w_rd_nxt)
        r_rd_addr <= r_addr;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign err     = r_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a frame-level reference model queues expected strobes.
module tb_uart_cmd_parser;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
  } ev_t;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en, rd_en, err;
  logic [7:0] wr_addr, wr_data, rd_addr;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  ev_t        exp_q[$];
  logic [7:0] fr[$];
  bit         discarding = 1'b0;
  logic [7:0] m_wa = 8'h00;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_ra = 8'h00;

  uart_cmd_parser #(.TIMEOUT_TICKS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic bit is_term(input logic [7:0] b);
    return (b == 8'h0A) || (b == 8'h0D);
  endfunction

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexchar(input int v, input bit lower);
    if (v < 10) return 8'(48 + v);
    return lower ? 8'(87 + v) : 8'(55 + v);
  endfunction

  // Frame-level model: position k in the current frame dictates what byte is legal.
  task automatic model_byte(input logic [7:0] b, input int ecyc);
    int  k, len;
    bit  ok;
    ev_t e;
    if (discarding) begin
      if (is_term(b)) discarding = 1'b0;
      return;
    end
    if (fr.size() == 0 && is_term(b)) return;
    fr.push_back(b);
    k   = fr.size() - 1;
    len = (fr[0] == 8'h57) ? 6 : 4;
    if (k == 0)            ok = (b == 8'h57) || (b == 8'h52);
    else if (k == len - 1) ok = is_term(b);
    else                   ok = (hexval(b) >= 0);
    e.cyc = ecyc;
    if (!ok) begin
      e.kind     = K_ERR;
      discarding = !is_term(b);
      fr.delete();
    end else if (k == len - 1) begin
      if (fr[0] == 8'h57) begin
        m_wa   = 8'(hexval(fr[1]) * 16 + hexval(fr[2]));
        m_wd   = 8'(hexval(fr[3]) * 16 + hexval(fr[4]));
        e.kind = K_WR;
      end else begin
        m_ra   = 8'(hexval(fr[1]) * 16 + hexval(fr[2]));
        e.kind = K_RD;
      end
      fr.delete();
    end else begin
      return;
    end
    e.wa = m_wa;
    e.wd = m_wd;
    e.ra = m_ra;
    exp_q.push_back(e);
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic model_timeout(input int ecyc);
    ev_t e;
    if (!discarding && fr.size() > 0) begin
      fr.delete();
      e.kind = K_ERR;
      e.cyc  = ecyc;
      e.wa   = m_wa;
      e.wd   = m_wd;
      e.ra   = m_ra;
      exp_q.push_back(e);
    end
  endtask
`endif

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b, cyc + 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      idle(gap);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},   int'(wr_en),   0);
    check({tag, "_rd_en"},   int'(rd_en),   0);
    check({tag, "_err"},     int'(err),     0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
  endtask

  // Monitor: every strobe must match the oldest expected event, including its cycle.
  initial begin
    ev_t e;
    int  act;
    forever begin
      @(negedge clk);
      if (rst_n && (wr_en || rd_en || err)) begin
        check("exclusive", int'(wr_en) + int'(rd_en) + int'(err), 1);
        act = wr_en ? K_WR : (rd_en ? K_RD : K_ERR);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", act, cyc);
        end else begin
          e = exp_q.pop_front();
          check("kind",    act,           e.kind);
          check("latency", cyc,           e.cyc);
          check("wr_addr", int'(wr_addr), int'(e.wa));
          check("wr_data", int'(wr_data), int'(e.wd));
          check("rd_addr", int'(rd_addr), int'(e.ra));
        end
      end
    end
  end

  initial begin
    logic [7:0] bq[$];
    int         sel, cut;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    send_str("W3A5C\n", 1);
    send_str("R7f\r", 1);
    send_str("WZ1\n", 1);
    send_str("R01\n", 1);
    send_str("W12\n", 1);
    send_str("R10\n", 2);
    send_str("W0102\n", 0);
    send_str("\r\n", 0);
    idle(3);

    send_str("W1", 1);
    for (int i = 0; i < 16; i++) begin
      baud_tick = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
      if (i == 15) model_timeout(cyc + 1);
`endif
      @(negedge clk);
      baud_tick = 1'b0;
      @(negedge clk);
    end
    send_str("R22\n", 1);
    idle(3);

    send_str("W12", 1);
    rst_n = 1'b0;
    fr.delete();
    discarding = 1'b0;
    m_wa = 8'h00;
    m_wd = 8'h00;
    m_ra = 8'h00;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_str("R33\n", 1);

    for (int f = 0; f < 300; f++) begin
      bq.delete();
      sel = $urandom_range(0, 5);
      if (sel == 5) begin
        if ($urandom_range(0, 1) == 1) bq.push_back(8'($urandom_range(0, 255)));
      end else begin
        bq.push_back((sel == 2) ? 8'h52 : 8'h57);
        for (int i = 0; i < ((sel == 2) ? 2 : 4); i++)
          bq.push_back(hexchar($urandom_range(0, 15), 1'($urandom_range(0, 1))));
        if (sel == 3) begin
          bq[$urandom_range(0, bq.size() - 1)] = 8'($urandom_range(0, 255));
        end else if (sel == 4) begin
          cut = $urandom_range(1, bq.size() - 1);
          while (bq.size() > cut) void'(bq.pop_back());
        end
      end
      bq.push_back(($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D);
      foreach (bq[i]) begin
        send_byte(bq[i]);
        idle($urandom_range(0, 3));
      end
    end

    idle(5);
    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
